// File: rtl/lstm_seq_ctrl.sv
// Sequencer for the two-layer LSTM datapath: clears, accumulate enables, addresses, writeback strobes.
// Latency: outputs registered, aligned with FSM state; busy rises one cycle after an accepted start.
// Backpressure: none; start is honoured only in IDLE. LSTM_CTRL_LAYR2_EN builds the layer-2 schedule.
module lstm_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int TIMESTEP    = 7,
    parameter int LAYR1_INPUT = 53,
    parameter int LAYR1_CELL  = 53,
    parameter int LAYR2_CELL  = 8,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rst_1,
    output logic              rst_2,
    output logic              acc_x_1,
    output logic              acc_h_1,
    output logic              acc_x_2,
    output logic              acc_h_2,
    output logic [ADDR_W-1:0] addr_x1,
    output logic [ADDR_W-1:0] rd_addr_h1,
    output logic [ADDR_W-1:0] rd_addr_c1,
    output logic [ADDR_W-1:0] rd_addr_w_1,
    output logic [ADDR_W-1:0] rd_addr_u_1,
    output logic [ADDR_W-1:0] rd_addr_b_1,
    output logic              wr_h1,
    output logic              wr_c1,
    output logic [ADDR_W-1:0] wr_addr_h1,
    output logic [ADDR_W-1:0] wr_addr_c1,
    output logic [ADDR_W-1:0] rd_addr_x2,
    output logic [ADDR_W-1:0] rd_addr_h2,
    output logic [ADDR_W-1:0] rd_addr_c2,
    output logic [ADDR_W-1:0] rd_addr_w_2,
    output logic [ADDR_W-1:0] rd_addr_u_2,
    output logic [ADDR_W-1:0] rd_addr_b_2,
    output logic              wr_h2,
    output logic              wr_c2,
    output logic [ADDR_W-1:0] wr_addr_h2,
    output logic [ADDR_W-1:0] wr_addr_c2
);
    localparam int N1 = (LAYR1_INPUT > LAYR1_CELL) ? LAYR1_INPUT : LAYR1_CELL;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_L1_CLR = 4'd1;
    localparam logic [3:0] S_L1_ACC = 4'd2;
    localparam logic [3:0] S_L1_DRN = 4'd3;
    localparam logic [3:0] S_L1_WR  = 4'd4;
    localparam logic [3:0] S_DONE   = 4'd9;
`ifdef LSTM_CTRL_LAYR2_EN
    localparam int N2 = (LAYR1_CELL > LAYR2_CELL) ? LAYR1_CELL : LAYR2_CELL;
    localparam logic [3:0] S_L2_CLR = 4'd5;
    localparam logic [3:0] S_L2_ACC = 4'd6;
    localparam logic [3:0] S_L2_DRN = 4'd7;
    localparam logic [3:0] S_L2_WR  = 4'd8;
`endif

    typedef struct packed {
        logic busy, done, rst_1, rst_2, acc_x_1, acc_h_1, acc_x_2, acc_h_2;
        logic wr_h1, wr_c1, wr_h2, wr_c2;
        logic [ADDR_W-1:0] addr_x1, rd_addr_h1, rd_addr_c1, rd_addr_w_1;
        logic [ADDR_W-1:0] rd_addr_u_1, rd_addr_b_1, wr_addr_h1, wr_addr_c1;
        logic [ADDR_W-1:0] rd_addr_x2, rd_addr_h2, rd_addr_c2, rd_addr_w_2;
        logic [ADDR_W-1:0] rd_addr_u_2, rd_addr_b_2, wr_addr_h2, wr_addr_c2;
    } ctrl_t;

    logic [3:0]  state, state_n;
    logic [15:0] t, t_n, j, j_n, k, k_n, i, i_n;
    ctrl_t       ctrl_q, ctrl_d;
    int          ti, ji, ki, ii;
    logic        unused_cfg;

    assign unused_cfg = (WIDTH > 0) && (LAYR2_CELL > 0) && (k == k_n);

    function automatic logic [ADDR_W-1:0] mad(input int a, input int b, input int c);
        int r;
        r = a * b + c;
        return r[ADDR_W-1:0];
    endfunction

    // index held at the last valid element once its enable drops
    function automatic int clamp(input int v, input int n);
        return (v < n) ? v : n - 1;
    endfunction

    always_comb begin
        state_n = state;
        t_n = t;
        j_n = j;
        k_n = k;
        i_n = i;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_L1_CLR;
                t_n = '0; j_n = '0; k_n = '0; i_n = '0;
            end
            S_L1_CLR: begin state_n = S_L1_ACC; i_n = '0; end
            S_L1_ACC: if (int'(i) == N1 - 1) state_n = S_L1_DRN; else i_n = i + 16'd1;
            S_L1_DRN: state_n = S_L1_WR;
            S_L1_WR: begin
                i_n = '0;
                if (int'(j) < LAYR1_CELL - 1) begin
                    j_n = j + 16'd1;
                    state_n = S_L1_CLR;
                end else begin
                    j_n = '0;
`ifdef LSTM_CTRL_LAYR2_EN
                    state_n = S_L2_CLR;
`else
                    if (int'(t) < TIMESTEP - 1) begin
                        t_n = t + 16'd1;
                        state_n = S_L1_CLR;
                    end else begin
                        state_n = S_DONE;
                    end
`endif
                end
            end
`ifdef LSTM_CTRL_LAYR2_EN
            S_L2_CLR: begin state_n = S_L2_ACC; i_n = '0; end
            S_L2_ACC: if (int'(i) == N2 - 1) state_n = S_L2_DRN; else i_n = i + 16'd1;
            S_L2_DRN: state_n = S_L2_WR;
            S_L2_WR: begin
                i_n = '0;
                if (int'(k) < LAYR2_CELL - 1) begin
                    k_n = k + 16'd1;
                    state_n = S_L2_CLR;
                end else if (int'(t) < TIMESTEP - 1) begin
                    k_n = '0;
                    t_n = t + 16'd1;
                    state_n = S_L1_CLR;
                end else begin
                    state_n = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
                t_n = '0; j_n = '0; k_n = '0; i_n = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // outputs decoded from the next state so the registered copy lines up with the state register
    always_comb begin
        ctrl_d = '0;
        ti = int'(t_n);
        ji = int'(j_n);
        ki = int'(k_n);
        ii = int'(i_n);
        ctrl_d.busy    = (state_n != S_IDLE) && (state_n != S_DONE);
        ctrl_d.done    = (state_n == S_DONE);
        ctrl_d.rst_1   = !ctrl_d.busy || (state_n == S_L1_CLR);
        ctrl_d.acc_x_1 = (state_n == S_L1_ACC) && (ii < LAYR1_INPUT);
        ctrl_d.acc_h_1 = (state_n == S_L1_ACC) && (ii < LAYR1_CELL);
        ctrl_d.wr_h1   = (state_n == S_L1_WR);
        ctrl_d.wr_c1   = (state_n == S_L1_WR);
        if (state_n inside {S_L1_CLR, S_L1_ACC, S_L1_DRN, S_L1_WR}) begin
            ctrl_d.addr_x1     = mad(ti, LAYR1_INPUT, clamp(ii, LAYR1_INPUT));
            ctrl_d.rd_addr_h1  = mad(ti, LAYR1_CELL, clamp(ii, LAYR1_CELL));
            ctrl_d.rd_addr_c1  = mad(ti, LAYR1_CELL, ji);
            ctrl_d.rd_addr_w_1 = mad(ji, LAYR1_INPUT, clamp(ii, LAYR1_INPUT));
            ctrl_d.rd_addr_u_1 = mad(ji, LAYR1_CELL, clamp(ii, LAYR1_CELL));
            ctrl_d.rd_addr_b_1 = mad(0, 0, ji);
            ctrl_d.wr_addr_h1  = mad(ti + 1, LAYR1_CELL, ji);
            ctrl_d.wr_addr_c1  = mad(ti + 1, LAYR1_CELL, ji);
        end
`ifdef LSTM_CTRL_LAYR2_EN
        ctrl_d.rst_2   = !ctrl_d.busy || (state_n == S_L2_CLR);
        ctrl_d.acc_x_2 = (state_n == S_L2_ACC) && (ii < LAYR1_CELL);
        ctrl_d.acc_h_2 = (state_n == S_L2_ACC) && (ii < LAYR2_CELL);
        ctrl_d.wr_h2   = (state_n == S_L2_WR);
        ctrl_d.wr_c2   = (state_n == S_L2_WR);
        if (state_n inside {S_L2_CLR, S_L2_ACC, S_L2_DRN, S_L2_WR}) begin
            ctrl_d.rd_addr_x2  = mad(ti + 1, LAYR1_CELL, clamp(ii, LAYR1_CELL));
            ctrl_d.rd_addr_h2  = mad(ti, LAYR2_CELL, clamp(ii, LAYR2_CELL));
            ctrl_d.rd_addr_c2  = mad(ti, LAYR2_CELL, ki);
            ctrl_d.rd_addr_w_2 = mad(ki, LAYR1_CELL, clamp(ii, LAYR1_CELL));
            ctrl_d.rd_addr_u_2 = mad(ki, LAYR2_CELL, clamp(ii, LAYR2_CELL));
            ctrl_d.rd_addr_b_2 = mad(0, 0, ki);
            ctrl_d.wr_addr_h2  = mad(ti + 1, LAYR2_CELL, ki);
            ctrl_d.wr_addr_c2  = mad(ti + 1, LAYR2_CELL, ki);
        end
`else
        ctrl_d.rst_2 = 1'b1;
        ki = 0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            t <= '0;
            j <= '0;
            k <= '0;
            i <= '0;
            ctrl_q <= '0;
            ctrl_q.rst_1 <= 1'b1;
            ctrl_q.rst_2 <= 1'b1;
        end else begin
            state <= state_n;
            t <= t_n;
            j <= j_n;
            k <= k_n;
            i <= i_n;
            ctrl_q <= ctrl_d;
        end
    end

    assign busy = ctrl_q.busy;
    assign done = ctrl_q.done;
    assign rst_1 = ctrl_q.rst_1;
    assign rst_2 = ctrl_q.rst_2;
    assign acc_x_1 = ctrl_q.acc_x_1;
    assign acc_h_1 = ctrl_q.acc_h_1;
    assign acc_x_2 = ctrl_q.acc_x_2;
    assign acc_h_2 = ctrl_q.acc_h_2;
    assign addr_x1 = ctrl_q.addr_x1;
    assign rd_addr_h1 = ctrl_q.rd_addr_h1;
    assign rd_addr_c1 = ctrl_q.rd_addr_c1;
    assign rd_addr_w_1 = ctrl_q.rd_addr_w_1;
    assign rd_addr_u_1 = ctrl_q.rd_addr_u_1;
    assign rd_addr_b_1 = ctrl_q.rd_addr_b_1;
    assign wr_h1 = ctrl_q.wr_h1;
    assign wr_c1 = ctrl_q.wr_c1;
    assign wr_addr_h1 = ctrl_q.wr_addr_h1;
    assign wr_addr_c1 = ctrl_q.wr_addr_c1;
    assign rd_addr_x2 = ctrl_q.rd_addr_x2;
    assign rd_addr_h2 = ctrl_q.rd_addr_h2;
    assign rd_addr_c2 = ctrl_q.rd_addr_c2;
    assign rd_addr_w_2 = ctrl_q.rd_addr_w_2;
    assign rd_addr_u_2 = ctrl_q.rd_addr_u_2;
    assign rd_addr_b_2 = ctrl_q.rd_addr_b_2;
    assign wr_h2 = ctrl_q.wr_h2;
    assign wr_c2 = ctrl_q.wr_c2;
    assign wr_addr_h2 = ctrl_q.wr_addr_h2;
    assign wr_addr_c2 = ctrl_q.wr_addr_c2;
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: a small-parameter instance checked cycle by cycle from a table,
// and a default instance checked by writeback scoreboards, cycle counts, restart and reset abort.
module tb_lstm_seq_ctrl;
    localparam int AW = 12;
`ifdef LSTM_CTRL_LAYR2_EN
    localparam int EXP_S_BUSY = 34;
    localparam int EXP_D_BUSY = 23912;
    localparam int EXP_D_WR2  = 56;
    localparam int EXP_D_LAST2 = 63;
`else
    localparam int EXP_S_BUSY = 24;
    localparam int EXP_D_BUSY = 20776;
    localparam int EXP_D_WR2  = 0;
    localparam int EXP_D_LAST2 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n, start_s, start_d;
    always #5 clk = ~clk;

    logic busy_s, done_s, rst_1_s, rst_2_s, acc_x_1_s, acc_h_1_s, acc_x_2_s, acc_h_2_s;
    logic wr_h1_s, wr_c1_s, wr_h2_s, wr_c2_s;
    logic [AW-1:0] addr_x1_s, rd_addr_h1_s, rd_addr_c1_s, rd_addr_w_1_s, rd_addr_u_1_s, rd_addr_b_1_s;
    logic [AW-1:0] wr_addr_h1_s, wr_addr_c1_s, rd_addr_x2_s, rd_addr_h2_s, rd_addr_c2_s;
    logic [AW-1:0] rd_addr_w_2_s, rd_addr_u_2_s, rd_addr_b_2_s, wr_addr_h2_s, wr_addr_c2_s;

    logic busy_d, done_d, rst_1_d, rst_2_d, acc_x_1_d, acc_h_1_d, acc_x_2_d, acc_h_2_d;
    logic wr_h1_d, wr_c1_d, wr_h2_d, wr_c2_d;
    logic [AW-1:0] addr_x1_d, rd_addr_h1_d, rd_addr_c1_d, rd_addr_w_1_d, rd_addr_u_1_d, rd_addr_b_1_d;
    logic [AW-1:0] wr_addr_h1_d, wr_addr_c1_d, rd_addr_x2_d, rd_addr_h2_d, rd_addr_c2_d;
    logic [AW-1:0] rd_addr_w_2_d, rd_addr_u_2_d, rd_addr_b_2_d, wr_addr_h2_d, wr_addr_c2_d;

    lstm_seq_ctrl #(.WIDTH(32), .TIMESTEP(2), .LAYR1_INPUT(3), .LAYR1_CELL(2), .LAYR2_CELL(1), .ADDR_W(AW)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
        .rst_1(rst_1_s), .rst_2(rst_2_s), .acc_x_1(acc_x_1_s), .acc_h_1(acc_h_1_s),
        .acc_x_2(acc_x_2_s), .acc_h_2(acc_h_2_s),
        .addr_x1(addr_x1_s), .rd_addr_h1(rd_addr_h1_s), .rd_addr_c1(rd_addr_c1_s),
        .rd_addr_w_1(rd_addr_w_1_s), .rd_addr_u_1(rd_addr_u_1_s), .rd_addr_b_1(rd_addr_b_1_s),
        .wr_h1(wr_h1_s), .wr_c1(wr_c1_s), .wr_addr_h1(wr_addr_h1_s), .wr_addr_c1(wr_addr_c1_s),
        .rd_addr_x2(rd_addr_x2_s), .rd_addr_h2(rd_addr_h2_s), .rd_addr_c2(rd_addr_c2_s),
        .rd_addr_w_2(rd_addr_w_2_s), .rd_addr_u_2(rd_addr_u_2_s), .rd_addr_b_2(rd_addr_b_2_s),
        .wr_h2(wr_h2_s), .wr_c2(wr_c2_s), .wr_addr_h2(wr_addr_h2_s), .wr_addr_c2(wr_addr_c2_s)
    );

    lstm_seq_ctrl dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
        .rst_1(rst_1_d), .rst_2(rst_2_d), .acc_x_1(acc_x_1_d), .acc_h_1(acc_h_1_d),
        .acc_x_2(acc_x_2_d), .acc_h_2(acc_h_2_d),
        .addr_x1(addr_x1_d), .rd_addr_h1(rd_addr_h1_d), .rd_addr_c1(rd_addr_c1_d),
        .rd_addr_w_1(rd_addr_w_1_d), .rd_addr_u_1(rd_addr_u_1_d), .rd_addr_b_1(rd_addr_b_1_d),
        .wr_h1(wr_h1_d), .wr_c1(wr_c1_d), .wr_addr_h1(wr_addr_h1_d), .wr_addr_c1(wr_addr_c1_d),
        .rd_addr_x2(rd_addr_x2_d), .rd_addr_h2(rd_addr_h2_d), .rd_addr_c2(rd_addr_c2_d),
        .rd_addr_w_2(rd_addr_w_2_d), .rd_addr_u_2(rd_addr_u_2_d), .rd_addr_b_2(rd_addr_b_2_d),
        .wr_h2(wr_h2_d), .wr_c2(wr_c2_d), .wr_addr_h2(wr_addr_h2_d), .wr_addr_c2(wr_addr_c2_d)
    );

    int n_tests = 0;
    int n_fail = 0;
    int q1[$];
    int q2[$];

    typedef struct {
        logic [3:0] fl;   // {rst_1, acc_x_1, acc_h_1, wr_h1}
        int x1, h1, w1, wa;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int or_d_addr();
        logic [AW-1:0] r;
        r = addr_x1_d | rd_addr_h1_d | rd_addr_c1_d | rd_addr_w_1_d | rd_addr_u_1_d | rd_addr_b_1_d
          | wr_addr_h1_d | wr_addr_c1_d | rd_addr_x2_d | rd_addr_h2_d | rd_addr_c2_d | rd_addr_w_2_d
          | rd_addr_u_2_d | rd_addr_b_2_d | wr_addr_h2_d | wr_addr_c2_d;
        return int'(r);
    endfunction

    function automatic int ctl_d();
        return int'({busy_d, done_d, rst_1_d, rst_2_d, acc_x_1_d, acc_h_1_d, acc_x_2_d, acc_h_2_d,
                     wr_h1_d, wr_c1_d, wr_h2_d, wr_c2_d});
    endfunction

    function automatic int ctl_s();
        return int'({busy_s, done_s, rst_1_s, rst_2_s, acc_x_1_s, acc_h_1_s, acc_x_2_s, acc_h_2_s,
                     wr_h1_s, wr_c1_s, wr_h2_s, wr_c2_s});
    endfunction

    task automatic pop_cmp(input string name, input bit use_q2, input int act);
        int e;
        if (use_q2 ? (q2.size() == 0) : (q1.size() == 0)) begin
            check({name, "_unexpected"}, act, -1);
        end else begin
            e = use_q2 ? q2.pop_front() : q1.pop_front();
            check(name, act, e);
        end
    endtask

    task automatic run_small();
        int n, busy_cnt, ax, ah, rc, done_n;
        busy_cnt = 0; ax = 0; ah = 0; rc = 0; done_n = -1;
        q1.delete(); q2.delete();
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < 2; j++) q1.push_back((t + 1) * 2 + j);
`ifdef LSTM_CTRL_LAYR2_EN
            q2.push_back(t + 1);
`endif
        end
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (n < 12) begin
                check($sformatf("s_flags_n%0d", n), int'({rst_1_s, acc_x_1_s, acc_h_1_s, wr_h1_s}), int'(tbl[n].fl));
                check($sformatf("s_addr_n%0d", n),
                      int'({addr_x1_s, rd_addr_h1_s, rd_addr_w_1_s, wr_addr_h1_s}),
                      int'({AW'(tbl[n].x1), AW'(tbl[n].h1), AW'(tbl[n].w1), AW'(tbl[n].wa)}));
            end
            busy_cnt += int'(busy_s);
            ax += int'(acc_x_1_s);
            ah += int'(acc_h_1_s);
            rc += int'(rst_1_s && busy_s);
            if (wr_h1_s) pop_cmp("s_wr_addr_h1", 1'b0, int'(wr_addr_h1_s));
            if (wr_h2_s) pop_cmp("s_wr_addr_h2", 1'b1, int'(wr_addr_h2_s));
            if (done_s) begin done_n = n; break; end
            @(negedge clk);
        end
        check("s_done_offset", done_n, EXP_S_BUSY);
        check("s_busy_cycles", busy_cnt, EXP_S_BUSY);
        check("s_acc_x_1_cycles", ax, 12);
        check("s_acc_h_1_cycles", ah, 8);
        check("s_rst_1_busy_cycles", rc, 4);
        check("s_q_left", q1.size() + q2.size(), 0);
        @(negedge clk);
        check("s_idle_ctl", ctl_s(), 12'b0011_0000_0000);
    endtask

    task automatic run_default();
        int n, busy_cnt, w1, w2, last1, last2, done_n, l2clr, idx, stray;
        busy_cnt = 0; w1 = 0; w2 = 0; last1 = 0; last2 = 0; done_n = -1; l2clr = 0; idx = 0; stray = 0;
        q1.delete(); q2.delete();
        for (int t = 0; t < 7; t++) begin
            for (int j = 0; j < 53; j++) q1.push_back((t + 1) * 53 + j);
`ifdef LSTM_CTRL_LAYR2_EN
            for (int k = 0; k < 8; k++) q2.push_back((t + 1) * 8 + k);
`endif
        end
        @(negedge clk) start_d = 1'b1;
        @(negedge clk) start_d = 1'b0;
        for (n = 0; n < 30000; n++) begin
            start_d = (n == 100) || (n == 5000);
            busy_cnt += int'(busy_d);
            if (wr_h1_d) begin w1++; last1 = int'(wr_addr_h1_d); pop_cmp("d_wr_addr_h1", 1'b0, last1); end
            if (wr_h2_d) begin w2++; last2 = int'(wr_addr_h2_d); pop_cmp("d_wr_addr_h2", 1'b1, last2); end
`ifdef LSTM_CTRL_LAYR2_EN
            if (rst_2_d && busy_d) begin
                l2clr++;
                idx = 0;
            end else if (l2clr == 4 && acc_x_2_d) begin
                check($sformatf("d_w2_k3_i%0d", idx), int'(rd_addr_w_2_d), 159 + idx);
                check($sformatf("d_x2_k3_i%0d", idx), int'(rd_addr_x2_d), 53 + idx);
                check($sformatf("d_h2en_k3_i%0d", idx), int'(acc_h_2_d), int'(idx < 8));
                idx++;
            end
`endif
            if (done_d) begin done_n = n; break; end
            @(negedge clk);
        end
        check("d_done_offset", done_n, EXP_D_BUSY);
        check("d_busy_cycles", busy_cnt, EXP_D_BUSY);
        check("d_wr_h1_pulses", w1, 371);
        check("d_wr_h2_pulses", w2, EXP_D_WR2);
        check("d_last_wr_addr_h1", last1, 423);
        check("d_last_wr_addr_h2", last2, EXP_D_LAST2);
        check("d_q_left", q1.size() + q2.size(), 0);
`ifdef LSTM_CTRL_LAYR2_EN
        check("d_k3_acc_cycles", idx, 53);
`endif
        // start held high across the DONE cycle must not relaunch
        start_d = 1'b1;
        @(negedge clk) start_d = 1'b0;
        for (int c = 0; c < 4; c++) begin
            stray += int'(busy_d || done_d);
            @(negedge clk);
        end
        check("d_no_restart_after_done", stray, 0);
    endtask

    task automatic run_abort();
        int n;
        bit hit;
        hit = 1'b0;
        @(negedge clk) start_d = 1'b1;
        @(negedge clk) start_d = 1'b0;
        for (n = 0; n < 30000; n++) begin
            if (acc_x_1_d && int'(addr_x1_d) >= 159) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        check("a_reached_t3_acc", int'(hit), 1);
        #2 rst_n = 1'b0;
        #1;
        check("a_async_ctl", ctl_d(), 12'b0011_0000_0000);
        check("a_async_addr", or_d_addr(), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("a_no_resume", ctl_d(), 12'b0011_0000_0000);
        start_d = 1'b1;
        @(negedge clk) start_d = 1'b0;
        check("a_restart_clr", int'({busy_d, rst_1_d, acc_x_1_d}), 3'b110);
        @(negedge clk);
        check("a_restart_acc", int'({acc_x_1_d, rst_1_d}), 2'b10);
        check("a_restart_addr_x1", int'(addr_x1_d), 0);
        check("a_restart_wr_addr_h1", int'(wr_addr_h1_d), 53);
    endtask

    initial begin
        tbl[0]  = '{4'b1000, 0, 0, 0, 2};
        tbl[1]  = '{4'b0110, 0, 0, 0, 2};
        tbl[2]  = '{4'b0110, 1, 1, 1, 2};
        tbl[3]  = '{4'b0100, 2, 1, 2, 2};
        tbl[4]  = '{4'b0000, 2, 1, 2, 2};
        tbl[5]  = '{4'b0001, 2, 1, 2, 2};
        tbl[6]  = '{4'b1000, 0, 0, 3, 3};
        tbl[7]  = '{4'b0110, 0, 0, 3, 3};
        tbl[8]  = '{4'b0110, 1, 1, 4, 3};
        tbl[9]  = '{4'b0100, 2, 1, 5, 3};
        tbl[10] = '{4'b0000, 2, 1, 5, 3};
        tbl[11] = '{4'b0001, 2, 1, 5, 3};

        rst_n = 1'b0; start_s = 1'b0; start_d = 1'b0;
        #23;
        check("r_ctl_d", ctl_d(), 12'b0011_0000_0000);
        check("r_addr_d", or_d_addr(), 0);
        check("r_ctl_s", ctl_s(), 12'b0011_0000_0000);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("r_idle_after_release", ctl_d(), 12'b0011_0000_0000);

        run_small();
        run_default();
        run_abort();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencer for the two-layer LSTM datapath: on a start pulse it steps through every timestep, every layer-1 cell and every layer-2 cell. For each cell it generates the datapath clears, accumulate enables, weight/bias/state read addresses and h/c write strobes. It replaces hand-driven sequencing and sits between the top-level host handshake and the `datapath` control ports.

## Interface
- `WIDTH`, 32, datapath word width (unused internally, passed for consistency)
- `TIMESTEP`, 7, timesteps per run
- `LAYR1_INPUT`, 53, layer-1 input vector length
- `LAYR1_CELL`, 53, layer-1 cell count
- `LAYR2_CELL`, 8, layer-2 cell count
- `ADDR_W`, 12, width of every address output
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle run request, honoured only in IDLE
- `busy` out 1: high from the first cycle after accepted start until DONE
- `done` out 1: one-cycle pulse at end of run
- `rst_1`, `rst_2` out 1: datapath layer-1/layer-2 accumulator clear, active high
- `acc_x_1`, `acc_h_1`, `acc_x_2`, `acc_h_2` out 1: accumulate enables
- `addr_x1`, `rd_addr_h1`, `rd_addr_c1`, `rd_addr_w_1`, `rd_addr_u_1`, `rd_addr_b_1` out ADDR_W: layer-1 read addresses
- `wr_h1`, `wr_c1` out 1; `wr_addr_h1`, `wr_addr_c1` out ADDR_W: layer-1 writeback
- `rd_addr_x2`, `rd_addr_h2`, `rd_addr_c2`, `rd_addr_w_2`, `rd_addr_u_2`, `rd_addr_b_2` out ADDR_W: layer-2 read addresses
- `wr_h2`, `wr_c2` out 1; `wr_addr_h2`, `wr_addr_c2` out ADDR_W: layer-2 writeback

## Operation
- Counters: t (timestep), j (layer-1 cell), k (layer-2 cell), i (accumulate index).
- States: IDLE, L1_CLR, L1_ACC, L1_DRN, L1_WR, L2_CLR, L2_ACC, L2_DRN, L2_WR, DONE.
- IDLE: start=1 → L1_CLR with t=j=k=0.
- Layer-1 cell sequence:
  - L1_CLR: 1 cycle, `rst_1`=1, i=0 → L1_ACC.
  - L1_ACC: N1=max(LAYR1_INPUT,LAYR1_CELL) cycles. `acc_x_1`=(i<LAYR1_INPUT), `acc_h_1`=(i<LAYR1_CELL).
  - L1_DRN: 1 cycle, all enables low.
  - L1_WR: 1 cycle, `wr_h1`=`wr_c1`=1. If j<LAYR1_CELL-1: j++, → L1_CLR; else j=0, → L2_CLR.
- Layer-2 cell sequence is identical, with N2=max(LAYR1_CELL,LAYR2_CELL), `acc_x_2`=(i<LAYR1_CELL), `acc_h_2`=(i<LAYR2_CELL).
  - After L2_WR: if k<LAYR2_CELL-1: k++, → L2_CLR.
  - Else if t<TIMESTEP-1: k=0, t++, → L1_CLR.
  - Else → DONE.
- DONE: `done`=1, `busy`=0, → IDLE.
- State memories hold TIMESTEP+1 slots. Slot 0 is the initial state; step t reads slot t and writes slot t+1.
- Layer-1 addresses:
  - `addr_x1`=t·LAYR1_INPUT+i
  - `rd_addr_h1`=t·LAYR1_CELL+i
  - `rd_addr_c1`=t·LAYR1_CELL+j
  - `wr_addr_h1`=`wr_addr_c1`=(t+1)·LAYR1_CELL+j
  - `rd_addr_w_1`=j·LAYR1_INPUT+i
  - `rd_addr_u_1`=j·LAYR1_CELL+i
  - `rd_addr_b_1`=j
- Layer-2 addresses:
  - `rd_addr_x2`=(t+1)·LAYR1_CELL+i
  - `rd_addr_h2`=t·LAYR2_CELL+i
  - `rd_addr_c2`=t·LAYR2_CELL+k
  - `wr_addr_h2`=`wr_addr_c2`=(t+1)·LAYR2_CELL+k
  - `rd_addr_w_2`=k·LAYR1_CELL+i
  - `rd_addr_u_2`=k·LAYR2_CELL+i
  - `rd_addr_b_2`=k
- Address rules: i indices are clamped to the active length when the enable is low. All addresses are truncated modulo 2^ADDR_W; the defaults never exceed 2808.
- `start` is ignored outside IDLE, including in DONE.

## Timing
- All outputs are registered, driven from the current state and counters. Addresses are valid in the same cycle as their enable.
- Reset values: state IDLE; all counters 0; `busy`=`done`=0; `rst_1`=`rst_2`=1; all `acc_*` and `wr_*` 0; all addresses 0.
- `rst_1`/`rst_2` stay 1 in IDLE and DONE.
- Accepted start in cycle 0 → L1_CLR in cycle 1, `busy`=1 from cycle 1.
- Cycle counts:
  - Per layer-1 cell: N1+3 cycles.
  - Per layer-2 cell: N2+3 cycles.
  - Per timestep: LAYR1_CELL·(N1+3)+LAYR2_CELL·(N2+3). Defaults: 53·56+8·56=3416.
  - Full default run: 23912 busy cycles; `done` is high in cycle 23913.
- `rst_n` low mid-run aborts immediately to the reset values. The run is not resumed; a fresh start is required.

## Configuration
- `LSTM_CTRL_LAYR2_EN` defined: full two-layer schedule as above.
- `LSTM_CTRL_LAYR2_EN` undefined:
  - The L2_* states are not built; after the last layer-1 cell, t advances or the FSM goes to DONE.
  - `rst_2` is held 1; all layer-2 enables, strobes and addresses are held 0.
  - Default run length is 53·56·7=20776 busy cycles.

## Test plan
- Reset: `rst_n`=0 → `busy`=0, `done`=0, `rst_1`=`rst_2`=1, all addresses 0; start pulse after release → `busy`=1 next cycle, `rst_1`=1 for exactly 1 cycle.
- Small config (TIMESTEP=2, LAYR1_INPUT=3, LAYR1_CELL=2, LAYR2_CELL=1):
  - N1=3, N2=2.
  - `acc_x_1` high 3 cycles and `acc_h_1` high 2 cycles per layer-1 cell.
  - `wr_addr_h1` sequence 2,3 in t=0 and 4,5 in t=1.
  - `done` after 2·(2·6+5)=34 busy cycles.
- Default config:
  - `done` pulses exactly 23912 cycles after busy rises.
  - 371 `wr_h1` pulses, 56 `wr_h2` pulses.
  - Last `wr_addr_h1`=423, last `wr_addr_h2`=63.
- Layer-2 addressing, default config, t=0, k=3: `rd_addr_w_2` runs 159..211, `rd_addr_x2` runs 53..105, `acc_h_2` high for the first 8 ACC cycles only.
- `start` re-pulsed while busy and during DONE → no restart; total cycle count unchanged.
- `rst_n` asserted in L1_ACC at t=3 → outputs return to reset values asynchronously; a new start then runs from t=0 with `addr_x1`=0.
